// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the CPU fetch port, the CPU data port and the shared memory port of
// the unified memory arbiter.
//   slave  : arbiter view (takes requests and memory read data, drives grants,
//            read responses and the memory command)
//   master : environment view (CPU ports plus memory model)
// Parameters:
//   XLEN : data width
//   ALEN : address width
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
    parameter int XLEN = 32,
    parameter int ALEN = 32
);
    // fetch port (read-only)
    logic            if_req;
    logic [ALEN-1:0] if_addr;
    logic            if_kill;
    logic            if_gnt;
    logic            if_rvalid;
    logic [31:0]     if_rdata;

    // data port (load/store)
    logic            d_req;
    logic            d_we;
    logic [ALEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_be;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    // shared memory port
    logic            mem_req;
    logic            mem_we;
    logic [ALEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port, fixed-latency, pipelined memory between the CPU
// fetch port (read-only) and the data port (load/store). The data port has
// priority; a fetch that has waited through STARVE_LIMIT consecutive data
// grants is forced through. Read responses are steered back by a pipeline of
// {valid, owner} tags that is RD_LATENCY stages deep. if_kill drops every
// in-flight fetch read, including one granted in the same cycle.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : unified_mem_arbiter_if.slave (fetch, data and memory signals)
// Parameters:
//   RD_LATENCY   : cycles from accepted read to mem_rdata valid (1..4)
//   STARVE_LIMIT : data grants allowed while fetch waits (1..15)
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unified_mem_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;
    logic       force_if;
    logic       if_gnt;
    logic       d_gnt;
    logic       d_store;

    logic [RD_LATENCY-1:0] valid_reg;
    logic [RD_LATENCY-1:0] owner_reg;   // 1 = fetch, 0 = data
    logic [RD_LATENCY-1:0] valid_next;
    logic [RD_LATENCY-1:0] owner_next;

    // Grants are purely a function of the request inputs and the starvation
    // count, so there is no path from mem_rdata into them. rst_n gates them so
    // nothing reaches the memory while the core is held in reset.
    always_comb begin
        force_if = bus.if_req & (starve_cnt_reg == LIMIT);
        d_gnt    = rst_n & bus.d_req & ~force_if;
        if_gnt   = rst_n & bus.if_req & (~bus.d_req | force_if);
        d_store  = d_gnt & bus.d_we;
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_req   = if_gnt | d_gnt;
    assign bus.mem_we    = d_store;
    assign bus.mem_be    = d_store ? bus.d_be : 4'b0000;
    // With no winner the data-port address is passed through; it is a
    // don't-care because mem_req is low.
    assign bus.mem_addr  = if_gnt ? bus.if_addr : bus.d_addr;
    assign bus.mem_wdata = bus.d_wdata;

    // The count only tracks a fetch that is actually waiting: any cycle
    // without a fetch request, or with a fetch grant, restarts it.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.if_req || if_gnt) begin
            starve_cnt_next = 4'd0;
        end else if (d_gnt && (starve_cnt_reg != LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    // Stage 0 captures the read granted this cycle; stores never enter.
    // A kill also clears the entry being written, so a fetch granted in the
    // kill cycle is dropped too.
    assign valid_next[0] = (if_gnt | (d_gnt & ~bus.d_we)) & ~(bus.if_kill & if_gnt);
    assign owner_next[0] = if_gnt;

    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
        assign valid_next[gi] = valid_reg[gi-1] & ~(bus.if_kill & owner_reg[gi-1]);
        assign owner_next[gi] = owner_reg[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= 4'd0;
            valid_reg      <= '0;
            owner_reg      <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            valid_reg      <= valid_next;
            owner_reg      <= owner_next;
        end
    end

    // The last stage lines up with mem_rdata. A fetch response leaving in the
    // kill cycle is still presented; the core discards it.
    assign bus.if_rvalid = valid_reg[RD_LATENCY-1] & owner_reg[RD_LATENCY-1];
    assign bus.d_rvalid  = valid_reg[RD_LATENCY-1] & ~owner_reg[RD_LATENCY-1];
    assign bus.if_rdata  = bus.mem_rdata[31:0];
    assign bus.d_rdata   = bus.mem_rdata;
endmodule
